mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_streak.sv | 43 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the memory-side blocks.
//   - ISA opcode / funct3 constants used by the fetch and LSU paths
//   - arbiter FSM state and owner encodings
//   - streak counter width (holds MAX_STREAK up to 15)
package mem_arbiter_pkg;

  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned OPCODE_W  = 7;

  localparam logic [OPCODE_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE = 7'b0100011;

  localparam logic [FUNCT3_W-1:0] FUNCT3_LB = 3'b000;
  localparam logic [FUNCT3_W-1:0] FUNCT3_LH = 3'b001;
  localparam logic [FUNCT3_W-1:0] FUNCT3_LW = 3'b010;

  localparam int unsigned STREAK_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_streak.sv
// arb_streak_counter: saturating counter of consecutive contended data grants.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (count -> 0)
//   inc_i   increment, saturating at MAX
//   clr_i   clear to 0 (priority over inc_i)
//   sat_o   count has reached MAX
module arb_streak_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [STREAK_W-1:0] MaxCnt = STREAK_W'(MAX);

  logic [STREAK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (fetch, data) arbiter onto one shared memory port,
// at most one transaction outstanding.
// Ports:
//   clk, rst                     clock, async active-low reset
//   if_req_i/if_addr_i           fetch read request (held until granted)
//   if_gnt_o/if_rvalid_o/if_rdata_o  fetch grant, response pulse, data
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_funct3_i  data request
//   d_gnt_o/d_rvalid_o/d_rdata_o data grant, response/store-ack pulse, data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_funct3_o  to memory
//   mem_rvalid_i/mem_rdata_i     memory completion
//   busy_o                       transaction outstanding
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [AWIDTH-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DWIDTH-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [FUNCT3_W-1:0] d_funct3_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [FUNCT3_W-1:0] mem_funct3_o,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i,
  output logic                busy_o
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;

  logic streak_sat;
  logic streak_inc;
  logic streak_clr;
  logic fetch_wins;

  arb_streak_counter #(
    .MAX (MAX_STREAK)
  ) u_streak (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (streak_inc),
    .clr_i  (streak_clr),
    .sat_o  (streak_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_FETCH;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    if_gnt_o     = 1'b0;
    d_gnt_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_funct3_o = '0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    d_rvalid_o   = 1'b0;
    d_rdata_o    = '0;
    streak_inc   = 1'b0;
    streak_clr   = 1'b0;
    // Data has priority unless it has starved fetch for MAX_STREAK grants.
    fetch_wins   = if_req_i && (!d_req_i || streak_sat);

    // Grants are combinational from the request inputs, so reset must gate
    // them explicitly to keep every output low while rst is asserted.
    if (rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (if_req_i || d_req_i) begin
            mem_req_o = 1'b1;
            state_d   = ARB_WAIT;
            if (fetch_wins) begin
              if_gnt_o     = 1'b1;
              owner_d      = OWNER_FETCH;
              mem_addr_o   = if_addr_i;
              mem_funct3_o = FUNCT3_LW;
              streak_clr   = 1'b1;
            end else begin
              d_gnt_o      = 1'b1;
              owner_d      = OWNER_DATA;
              mem_we_o     = d_we_i;
              mem_addr_o   = d_addr_i;
              mem_wdata_o  = d_wdata_i;
              mem_funct3_o = d_funct3_i;
              // Only grants that pass over a waiting fetch count as a streak.
              streak_inc   = if_req_i;
            end
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid_i) begin
            state_d = ARB_IDLE;
            if (owner_q == OWNER_FETCH) begin
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i;
            end else begin
              d_rvalid_o  = 1'b1;
              d_rdata_o   = mem_rdata_i;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == ARB_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_funct3;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AWIDTH     (AW),
    .DWIDTH     (DW),
    .MAX_STREAK (MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .d_req_i      (d_req),
    .d_we_i       (d_we),
    .d_addr_i     (d_addr),
    .d_wdata_i    (d_wdata),
    .d_funct3_i   (d_funct3),
    .d_gnt_o      (d_gnt),
    .d_rvalid_o   (d_rvalid),
    .d_rdata_o    (d_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_funct3_o (mem_funct3),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction in flight; remembers who owns it, whether it is a store,
  // and how many data grants in a row have passed over a waiting fetch.
  bit   m_busy, m_data_owner, m_store;
  int   m_streak;
  logic e_if_gnt, e_d_gnt;
  bit   rec_en = 1'b0;
  byte  gseq[$];

  always @(negedge clk) begin
    logic          x_ifg, x_dg, x_mreq, x_mwe, x_ifrv, x_drv, x_busy, fetch_turn;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, x_ifrd, x_drd;
    logic [2:0]    x_f3;
    x_ifg = 0; x_dg = 0; x_mreq = 0; x_mwe = 0; x_ifrv = 0; x_drv = 0; x_busy = 0;
    x_addr = '0; x_wdata = '0; x_ifrd = '0; x_drd = '0; x_f3 = '0; fetch_turn = 0;
    if (rst) begin
      x_busy = m_busy;
      if (!m_busy) begin
        if (if_req || d_req) begin
          fetch_turn = if_req && (!d_req || (m_streak == int'(MS)));
          x_mreq = 1;
          if (fetch_turn) begin
            x_ifg = 1; x_addr = if_addr; x_f3 = 3'b010;
          end else begin
            x_dg = 1; x_mwe = d_we; x_addr = d_addr; x_wdata = d_wdata; x_f3 = d_funct3;
          end
        end
      end else if (mem_rvalid) begin
        if (m_data_owner) begin x_drv = 1; x_drd = mem_rdata; end
        else begin x_ifrv = 1; x_ifrd = mem_rdata; end
      end
    end
    e_if_gnt = x_ifg;
    e_d_gnt  = x_dg;

    chk("m_if_gnt", if_gnt, x_ifg);
    chk("m_d_gnt", d_gnt, x_dg);
    chk("m_mem_req", mem_req, x_mreq);
    chk("m_busy", busy, x_busy);
    chk("m_if_rvalid", if_rvalid, x_ifrv);
    chk("m_d_rvalid", d_rvalid, x_drv);
    chk("m_if_rdata", if_rdata, x_ifrd);
    if (!(x_drv && m_store)) chk("m_d_rdata", d_rdata, x_drd);
    if (x_mreq) begin
      chk("m_mem_we", mem_we, x_mwe);
      chk("m_mem_addr", mem_addr, x_addr);
      chk("m_mem_f3", mem_funct3, x_f3);
      if (x_dg) chk("m_mem_wdata", mem_wdata, x_wdata);
    end
    if (rec_en && if_gnt) gseq.push_back("F");
    if (rec_en && d_gnt)  gseq.push_back("D");
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_data_owner = 0; m_store = 0; m_streak = 0;
    end else if (m_busy) begin
      if (mem_rvalid) m_busy = 0;
    end else if (e_if_gnt) begin
      m_busy = 1; m_data_owner = 0; m_store = 0; m_streak = 0;
    end else if (e_d_gnt) begin
      m_busy = 1; m_data_owner = 1; m_store = d_we;
      if (if_req && m_streak < int'(MS)) m_streak = m_streak + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Both masters request continuously; memory answers one cycle after each
  // grant. Starting from a cleared streak the order must be DDDDFDDDDF.
  task automatic run_contention(input string tag);
    string exp_seq;
    exp_seq = "DDDDFDDDDF";
    gseq.delete();
    if_req = 1; if_addr = 32'h0100_0004;
    d_req = 1; d_we = 0; d_addr = 32'h0100_0200; d_funct3 = 3'b010;
    rec_en = 1;
    for (int i = 0; i < 20; i++) begin
      mem_rvalid = (i % 2 == 1);
      mem_rdata  = 32'h1000 + i;
      cyc();
    end
    rec_en = 0; if_req = 0; d_req = 0; mem_rvalid = 0; mem_rdata = '0;
    chk({tag, "_len"}, 64'(gseq.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < gseq.size()) chk($sformatf("%s_%0d", tag, i), gseq[i], exp_seq[i]);
    end
  endtask

  initial begin
    rst = 0; if_req = 1; if_addr = '0; d_req = 1; d_we = 0; d_addr = '0;
    d_wdata = '0; d_funct3 = '0; mem_rvalid = 0; mem_rdata = '0;

    // reset holds every output low even with both requests up
    repeat (2) begin
      @(negedge clk);
      chk("rst_if_gnt", if_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_req", mem_req, 0); chk("rst_busy", busy, 0);
    end
    cyc(); rst = 1; if_req = 0; d_req = 0;
    cyc();

    // single fetch, 1-cycle response
    if_req = 1; if_addr = 32'h0100_0000;
    @(negedge clk);
    chk("f_gnt", if_gnt, 1); chk("f_addr", mem_addr, 32'h0100_0000);
    chk("f_we", mem_we, 0); chk("f_f3", mem_funct3, 3'b010);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("f_rvalid", if_rvalid, 1); chk("f_rdata", if_rdata, 32'h0000_0013); chk("f_busy1", busy, 1);
    cyc(); mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    chk("f_busy_end", busy, 0);
    cyc();

    run_contention("order");

    // store with 3-cycle ack while fetch waits
    d_req = 1; d_we = 1; d_addr = 32'h0100_0100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
    @(negedge clk);
    chk("st_gnt", d_gnt, 1); chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h0100_0100); chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc(); d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h0100_0008;
    for (int c = 1; c <= 3; c++) begin
      mem_rvalid = (c == 3); mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk($sformatf("st_no_ifgnt%0d", c), if_gnt, 0);
      chk($sformatf("st_no_dgnt%0d", c), d_gnt, 0);
      chk($sformatf("st_drv%0d", c), d_rvalid, (c == 3));
      chk($sformatf("st_no_ifrv%0d", c), if_rvalid, 0);
      cyc();
    end
    mem_rvalid = 0;
    @(negedge clk);
    chk("st_then_ifgnt", if_gnt, 1);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0010_0073;
    @(negedge clk);
    chk("st_then_ifrv", if_rvalid, 1); chk("st_then_ifrd", if_rdata, 32'h0010_0073);
    cyc(); mem_rvalid = 0;

    // stray completion in IDLE
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("idle_ifrv", if_rvalid, 0); chk("idle_drv", d_rvalid, 0);
    chk("idle_ifrd", if_rdata, 0); chk("idle_drd", d_rdata, 0);
    cyc(); mem_rvalid = 0;

    // reset during WAIT, late completion dropped
    d_req = 1; d_we = 0; d_addr = 32'h0100_0300;
    @(negedge clk);
    chk("rw_dgnt", d_gnt, 1);
    cyc(); d_req = 0; rst = 0;
    @(negedge clk);
    chk("rw_busy_rst", busy, 0); chk("rw_drv_rst", d_rvalid, 0);
    cyc(); rst = 1;
    @(negedge clk);
    chk("rw_busy_rel", busy, 0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw_late_ifrv", if_rvalid, 0); chk("rw_late_drv", d_rvalid, 0); chk("rw_late_busy", busy, 0);
    cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h0100_000C;
    @(negedge clk);
    chk("rw_next_gnt", if_gnt, 1);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_006F;
    @(negedge clk);
    chk("rw_next_rv", if_rvalid, 1);
    cyc(); mem_rvalid = 0;

    // load wins contention, then fetch served; owner routing
    if_req = 1; if_addr = 32'h0100_0010; d_req = 1; d_we = 0; d_addr = 32'h0100_0400;
    @(negedge clk);
    chk("ow_dgnt", d_gnt, 1); chk("ow_no_ifgnt", if_gnt, 0);
    cyc(); d_req = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    chk("ow_drv", d_rvalid, 1); chk("ow_drd", d_rdata, 32'hA5A5_0001); chk("ow_no_ifrv", if_rvalid, 0);
    cyc(); mem_rvalid = 0;
    @(negedge clk);
    chk("ow_ifgnt", if_gnt, 1);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("ow_ifrv", if_rvalid, 1); chk("ow_no_drv", d_rvalid, 0);
    cyc(); mem_rvalid = 0;

    // streak was cleared by the fetch grant: full DDDD run before fetch again
    run_contention("clr");

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
